alarm_trigger_module: RTL and testbench

ALARM_TRIGGER_MODULE -- requirements
Module: alarm_trigger_module

---
 rtl/alarm_trigger_module_pkg.sv | 26 ++
 rtl/mux_8x1_13bits.sv | 30 +++
 rtl/alarm_trigger_module.sv | 182 ++++++++++++++++++
 tb/tb_alarm_trigger_module.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_trigger_module_pkg.sv
// Shared alarm constants: state encodings, parameter defaults and the
// time-word layout helpers used by the alarm trigger logic.
package alarm_trigger_module_pkg;

   // Default timing and snooze budget for one alarm event
   localparam int RING_MINUTES_DEF   = 10;
   localparam int SNOOZE_MINUTES_DEF = 9;
   localparam int MAX_SNOOZE_DEF     = 3;

   // Day index 7 is outside the week and never selects an alarm register
   localparam logic [2:0] DAY_INVALID = 3'd7;

   // Alarm event state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2,
      ST_DONE    = 2'd3
   } alarm_state_e;

   // Counter width able to hold the value n (at least one bit)
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mux_8x1_13bits.sv
// Eight-way selector for 13-bit alarm registers (enable bit plus hh:mm).
module mux_8x1_13bits (
   input  logic [12:0] in0_i,
   input  logic [12:0] in1_i,
   input  logic [12:0] in2_i,
   input  logic [12:0] in3_i,
   input  logic [12:0] in4_i,
   input  logic [12:0] in5_i,
   input  logic [12:0] in6_i,
   input  logic [12:0] in7_i,
   input  logic [2:0]  sel_i,
   output logic [12:0] out_o
);

   // Pure combinational select of one of the eight inputs
   always_comb begin
      out_o = in0_i;
      case (sel_i)
         3'd0:    out_o = in0_i;
         3'd1:    out_o = in1_i;
         3'd2:    out_o = in2_i;
         3'd3:    out_o = in3_i;
         3'd4:    out_o = in4_i;
         3'd5:    out_o = in5_i;
         3'd6:    out_o = in6_i;
         default: out_o = in7_i;
      endcase
   end

endmodule

// File: rtl/alarm_trigger_module.sv
// Alarm trigger: detects minute edges on the current time word, matches
// them against the per-day alarm register, and runs the ring / snooze /
// done sequence for one alarm event.
//
// Buttons (STOP, SNOOZE) are single-cycle pulses sampled on the rising
// edge of CLK; there is no valid/ready handshake on this block.
module alarm_trigger_module
   import alarm_trigger_module_pkg::*;
#(
   parameter int RING_MINUTES   = RING_MINUTES_DEF,
   parameter int SNOOZE_MINUTES = SNOOZE_MINUTES_DEF,
   parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
   input  logic        CLK,
   input  logic        CLEAR,
   input  logic [15:0] CTO,
   input  logic [12:0] Q_r0,
   input  logic [12:0] Q_r1,
   input  logic [12:0] Q_r2,
   input  logic [12:0] Q_r3,
   input  logic [12:0] Q_r4,
   input  logic [12:0] Q_r5,
   input  logic [12:0] Q_r6,
   input  logic        STOP,
   input  logic        SNOOZE,
   output logic        ALARM,
   output logic        SNOOZING,
   output logic [1:0]  SNOOZE_LEFT,
   output logic [2:0]  MATCH_DAY,
   output logic [1:0]  state_dbg_o
);

   localparam int RING_W = cnt_width(RING_MINUTES);
   localparam int SNZ_W  = cnt_width(SNOOZE_MINUTES);

   localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_MINUTES);
   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MINUTES);
   localparam logic [1:0]        LEFT_LOAD = 2'(MAX_SNOOZE);
   localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
   localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

   alarm_state_e      state_q, state_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
   logic [1:0]        left_q, left_d;
   logic [2:0]        day_q, day_d;
   logic              alarm_q, alarm_d;
   logic              snoozing_q, snoozing_d;
   logic [11:0]       cto_q;
   logic              primed_q;

   logic [12:0]       sel_word;
   logic              master_on;
   logic              minute_edge;
   logic              match;

   // Alarm register for the current day; slot 7 is unused and tied off
   mux_8x1_13bits u_day_mux (
      .in0_i (Q_r0),
      .in1_i (Q_r1),
      .in2_i (Q_r2),
      .in3_i (Q_r3),
      .in4_i (Q_r4),
      .in5_i (Q_r5),
      .in6_i (Q_r6),
      .in7_i (13'd0),
      .sel_i (CTO[14:12]),
      .out_o (sel_word)
   );

   assign master_on = CTO[15];

   // An edge needs one sampled copy first, so the cycle after reset
   // release never reports one even if CTO already differs from zero.
   assign minute_edge = primed_q && (CTO[11:0] != cto_q);

   assign match = minute_edge && master_on &&
                  (CTO[14:12] != DAY_INVALID) &&
                  sel_word[12] && (sel_word[11:0] == CTO[11:0]);

   // State and datapath registers; CLEAR abandons any event immediately
   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         left_q     <= '0;
         day_q      <= '0;
         alarm_q    <= 1'b0;
         snoozing_q <= 1'b0;
         cto_q      <= '0;
         primed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         left_q     <= left_d;
         day_q      <= day_d;
         alarm_q    <= alarm_d;
         snoozing_q <= snoozing_d;
         cto_q      <= CTO[11:0];
         primed_q   <= 1'b1;
      end
   end

   // Next-state: master-off first, then STOP, then SNOOZE, then minute count
   always_comb begin
      state_d = state_q;
      if (!master_on) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (match) state_d = ST_RINGING;
            end
            ST_RINGING: begin
               if (STOP)
                  state_d = ST_DONE;
               else if (SNOOZE && (left_q != 2'd0))
                  state_d = ST_SNOOZE;
               else if (minute_edge && (ring_cnt_q <= RING_ONE))
                  state_d = ST_DONE;
            end
            ST_SNOOZE: begin
               if (STOP)
                  state_d = ST_DONE;
               else if (minute_edge && (snz_cnt_q <= SNZ_ONE))
                  state_d = ST_RINGING;
            end
            ST_DONE: begin
               // A match on this same edge is deliberately dropped
               if (minute_edge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs and counters derived from the current and next state
   always_comb begin
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      left_d     = left_q;
      day_d      = day_q;
      alarm_d    = (state_d == ST_RINGING);
      snoozing_d = (state_d == ST_SNOOZE);

      // Entering RINGING from IDLE starts a fresh event
      if ((state_q == ST_IDLE) && (state_d == ST_RINGING)) begin
         ring_cnt_d = RING_LOAD;
         left_d     = LEFT_LOAD;
         day_d      = CTO[14:12];
      end

      // Re-ring after snooze gets a full ring period
      if ((state_q == ST_SNOOZE) && (state_d == ST_RINGING))
         ring_cnt_d = RING_LOAD;

      // Ring countdown only when no button acted this cycle; saturates at 0
      if ((state_q == ST_RINGING) && (state_d != ST_SNOOZE) && !STOP &&
          minute_edge && (ring_cnt_q != '0))
         ring_cnt_d = ring_cnt_q - RING_ONE;

      // Taking a snooze spends one from the budget and arms the timer
      if ((state_q == ST_RINGING) && (state_d == ST_SNOOZE)) begin
         snz_cnt_d = SNZ_LOAD;
         left_d    = left_q - 2'd1;
      end

      // Snooze countdown, saturating at 0
      if ((state_q == ST_SNOOZE) && (state_d == ST_SNOOZE) &&
          minute_edge && (snz_cnt_q != '0))
         snz_cnt_d = snz_cnt_q - SNZ_ONE;
   end

   assign ALARM       = alarm_q;
   assign SNOOZING    = snoozing_q;
   assign SNOOZE_LEFT = left_q;
   assign MATCH_DAY   = day_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alarm_trigger_module.sv
// Directed bench for alarm_trigger_module: a table of one-cycle vectors
// with hand-computed state/SNOOZE_LEFT/MATCH_DAY, plus hand-written
// sequences for asynchronous clear and reset release.
module tb_alarm_trigger_module;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RING = 2'd1;
   localparam logic [1:0] S_SNZ  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // 07:25 packed as hour[11:7]=7, tens[6:4]=2, units[3:0]=5
   localparam logic [11:0] T0725 = 12'h3A5;
   // 08:00 packed the same way
   localparam logic [11:0] T0800 = 12'h400;

   logic        clk = 1'b0;
   logic        clear;
   logic [15:0] cto;
   logic [12:0] q_r0, q_r1, q_r2, q_r3, q_r4, q_r5, q_r6;
   logic        stop, snooze;
   logic        alarm, snoozing;
   logic [1:0]  snooze_left;
   logic [2:0]  match_day;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] cto;
      logic        en;
      logic        stop;
      logic        snz;
      logic [1:0]  st;
      logic [1:0]  left;
      logic [2:0]  day;
   } vec_t;

   vec_t vecs[$];

   // clock
   always #5 clk = ~clk;

   alarm_trigger_module dut (
      .CLK         (clk),
      .CLEAR       (clear),
      .CTO         (cto),
      .Q_r0        (q_r0),
      .Q_r1        (q_r1),
      .Q_r2        (q_r2),
      .Q_r3        (q_r3),
      .Q_r4        (q_r4),
      .Q_r5        (q_r5),
      .Q_r6        (q_r6),
      .STOP        (stop),
      .SNOOZE      (snooze),
      .ALARM       (alarm),
      .SNOOZING    (snoozing),
      .SNOOZE_LEFT (snooze_left),
      .MATCH_DAY   (match_day),
      .state_dbg_o (state_dbg)
   );

   function automatic logic [15:0] mk(input logic on, input int day, input int hh, input int mm);
      logic [15:0] w;
      w[15]    = on;
      w[14:12] = 3'(day);
      w[11:7]  = 5'(hh);
      w[6:4]   = 3'(mm / 10);
      w[3:0]   = 4'(mm % 10);
      return w;
   endfunction

   // Day 2, master on, 07:mm
   function automatic logic [15:0] t(input int mm);
      return mk(1'b1, 2, 7, mm);
   endfunction

   task automatic add(input logic [15:0] c, input logic en, input logic sp, input logic sz,
                      input logic [1:0] st, input logic [1:0] left, input logic [2:0] day);
      vec_t v;
      v.cto = c; v.en = en; v.stop = sp; v.snz = sz;
      v.st = st; v.left = left; v.day = day;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] left,
                            input logic [2:0] day);
      check({tag, " state"},    8'(state_dbg),   8'(st));
      check({tag, " alarm"},    8'(alarm),       8'(st == S_RING));
      check({tag, " snoozing"}, 8'(snoozing),    8'(st == S_SNZ));
      check({tag, " left"},     8'(snooze_left), 8'(left));
      check({tag, " day"},      8'(match_day),   8'(day));
   endtask

   // One vector = one clock: drive at negedge, sample at the next negedge
   task automatic apply(input vec_t v, input int idx);
      cto    = v.cto;
      q_r2   = {v.en, T0725};
      stop   = v.stop;
      snooze = v.snz;
      @(posedge clk);
      @(negedge clk);
      stop   = 1'b0;
      snooze = 1'b0;
      check_all($sformatf("vec%0d", idx), v.st, v.left, v.day);
   endtask

   initial begin
      vec_t v;

      // ---- match and auto-stop ----
      add(t(24), 1, 0, 0, S_IDLE, 0, 0);
      add(t(25), 1, 0, 0, S_RING, 3, 2);
      for (int m = 26; m <= 34; m++) add(t(m), 1, 0, 0, S_RING, 3, 2);
      add(t(35), 1, 0, 0, S_DONE, 3, 2);
      add(t(36), 1, 0, 0, S_IDLE, 3, 2);

      // ---- snooze three times, fourth ignored ----
      add(t(25), 1, 0, 0, S_RING, 3, 2);
      add(t(25), 1, 0, 1, S_SNZ,  2, 2);
      for (int m = 26; m <= 33; m++) add(t(m), 1, 0, 0, S_SNZ, 2, 2);
      add(t(34), 1, 0, 0, S_RING, 2, 2);
      add(t(34), 1, 0, 1, S_SNZ,  1, 2);
      for (int m = 35; m <= 42; m++) add(t(m), 1, 0, 0, S_SNZ, 1, 2);
      add(t(43), 1, 0, 0, S_RING, 1, 2);
      add(t(43), 1, 0, 1, S_SNZ,  0, 2);
      add(t(43), 1, 0, 1, S_SNZ,  0, 2);   // snooze press while snoozing ignored
      for (int m = 44; m <= 51; m++) add(t(m), 1, 0, 0, S_SNZ, 0, 2);
      add(t(52), 1, 0, 0, S_RING, 0, 2);
      add(t(52), 1, 0, 1, S_RING, 0, 2);   // fourth press: keeps ringing
      add(t(52), 1, 1, 1, S_DONE, 0, 2);
      add(t(25), 1, 0, 0, S_IDLE, 0, 2);   // match on the DONE edge dropped

      // ---- STOP+SNOOZE together on a minute edge ----
      add(t(24), 1, 0, 0, S_IDLE, 0, 2);
      add(t(25), 1, 0, 0, S_RING, 3, 2);
      add(t(26), 1, 1, 1, S_DONE, 3, 2);
      add(t(27), 1, 0, 0, S_IDLE, 3, 2);

      // ---- disabled / invalid matches ----
      add(t(25), 0, 0, 0, S_IDLE, 3, 2);                 // enable bit clear
      add(mk(1, 7, 7, 24), 1, 0, 0, S_IDLE, 3, 2);
      add(mk(1, 7, 7, 25), 1, 0, 0, S_IDLE, 3, 2);       // day 7
      add(mk(0, 2, 7, 24), 1, 0, 0, S_IDLE, 3, 2);
      add(mk(0, 2, 7, 25), 1, 0, 0, S_IDLE, 3, 2);       // master off

      // ---- another day's register selects and reports its day ----
      add(mk(1, 5, 8, 0), 1, 0, 0, S_RING, 3, 5);
      add(mk(1, 5, 8, 0), 1, 1, 0, S_DONE, 3, 5);
      add(mk(1, 5, 8, 1), 1, 0, 0, S_IDLE, 3, 5);

      // ---- master off while snoozing ----
      add(t(24), 1, 0, 0, S_IDLE, 3, 5);
      add(t(25), 1, 0, 0, S_RING, 3, 2);
      add(t(25), 1, 0, 1, S_SNZ,  2, 2);
      add(mk(0, 2, 7, 25), 1, 0, 0, S_IDLE, 2, 2);

      // reset
      clear  = 1'b1;
      cto    = t(20);
      stop   = 1'b0;
      snooze = 1'b0;
      q_r0 = {1'b1, T0800}; q_r1 = {1'b1, T0800}; q_r2 = {1'b1, T0725};
      q_r3 = {1'b1, T0800}; q_r4 = {1'b1, T0800}; q_r5 = {1'b1, T0800};
      q_r6 = {1'b1, T0800};
      repeat (3) @(negedge clk);
      check_all("reset", S_IDLE, 0, 0);
      clear = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // ---- asynchronous CLEAR mid-ring ----
      v = vecs[0];
      v.cto = t(24); v.st = S_IDLE; v.left = 2; v.day = 2;
      apply(v, 1000);
      v.cto = t(25); v.st = S_RING; v.left = 3;
      apply(v, 1001);
      #2 clear = 1'b1;
      #1;
      check_all("async_clear", S_IDLE, 0, 0);
      @(negedge clk);
      cto   = t(25);   // already equal to the alarm time at release
      clear = 1'b0;
      @(posedge clk); @(negedge clk);
      check_all("release_c1", S_IDLE, 0, 0);
      @(posedge clk); @(negedge clk);
      check_all("release_c2", S_IDLE, 0, 0);
      v.cto = t(24); v.st = S_IDLE; v.left = 0; v.day = 0;
      apply(v, 1002);
      v.cto = t(25); v.st = S_RING; v.left = 3; v.day = 2;
      apply(v, 1003);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
